// File: rtl/avalon_bridge_pkg.sv
// Shared helpers for the Avalon-MM pipeline bridge: log2 and command-word layout.
package avalon_bridge_pkg;

  // Ceiling log2, usable in parameter expressions (clog2(1) == 0).
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  // Command word, LSB first: byteenable, write, read, address, writedata.
  // Packed as {writedata, address, read, write, byteenable}.
  localparam int CMD_CTRL_BITS = 2;
  localparam int CMD_BE_LSB    = 0;

  function automatic int cmd_be_width(input int data_w);
    return data_w / 8;
  endfunction

  function automatic int cmd_wr_bit(input int data_w);
    return cmd_be_width(data_w);
  endfunction

  function automatic int cmd_rd_bit(input int data_w);
    return cmd_be_width(data_w) + 1;
  endfunction

  function automatic int cmd_addr_lsb(input int data_w);
    return cmd_be_width(data_w) + CMD_CTRL_BITS;
  endfunction

  function automatic int cmd_data_lsb(input int data_w, input int addr_w);
    return cmd_addr_lsb(data_w) + addr_w;
  endfunction

  function automatic int cmd_width(input int data_w, input int addr_w);
    return data_w + addr_w + cmd_be_width(data_w) + CMD_CTRL_BITS;
  endfunction

endpackage

// File: rtl/avalon_bridge_cmd_fifo.sv
// Synchronous command FIFO: register-array storage, combinational head read,
// no fall-through (a word pushed at edge N is at the head from cycle N+1).
module avalon_bridge_cmd_fifo
  import avalon_bridge_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 8,
  localparam int PTR_W = clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  // Status decodes come straight off the count register.
  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Next-state for storage, pointers (wrap naturally, DEPTH is a power of two) and count.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // State registers; storage is cleared so the idle head drives zeros.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/avalon_pipeline_bridge.sv
// Single-clock Avalon-MM pipeline bridge: command FIFO toward the master port,
// a hard cap on outstanding reads, a one-stage read response register and an
// idle flag software can poll before draining.
module avalon_pipeline_bridge
  import avalon_bridge_pkg::*;
#(
  parameter  int DATA_WIDTH        = 64,
  parameter  int ADDR_WIDTH        = 23,
  parameter  int CMD_DEPTH         = 8,
  parameter  int MAX_PENDING_READS = 8,
  localparam int BE                = DATA_WIDTH / 8,
  localparam int BA                = clog2(BE)
) (
  input  logic                       clk,
  input  logic                       reset,
  // slave side
  input  logic [ADDR_WIDTH-1:0]      slave_address,
  input  logic [BE-1:0]              slave_byteenable,
  input  logic                       slave_read,
  input  logic                       slave_write,
  input  logic [DATA_WIDTH-1:0]      slave_writedata,
  output logic                       slave_waitrequest,
  output logic [DATA_WIDTH-1:0]      slave_readdata,
  output logic                       slave_readdatavalid,
  output logic                       slave_endofpacket,
  // master side
  output logic [ADDR_WIDTH+BA-1:0]   master_address,
  output logic [BE-1:0]              master_byteenable,
  output logic                       master_read,
  output logic                       master_write,
  output logic [DATA_WIDTH-1:0]      master_writedata,
  input  logic                       master_waitrequest,
  input  logic [DATA_WIDTH-1:0]      master_readdata,
  input  logic                       master_readdatavalid,
  input  logic                       master_endofpacket,
  // status
  output logic                       bridge_idle
);

  localparam int MA_W     = ADDR_WIDTH + BA;
  localparam int CMD_W    = cmd_width(DATA_WIDTH, ADDR_WIDTH);
  localparam int WR_BIT   = cmd_wr_bit(DATA_WIDTH);
  localparam int RD_BIT   = cmd_rd_bit(DATA_WIDTH);
  localparam int ADDR_LSB = cmd_addr_lsb(DATA_WIDTH);
  localparam int DATA_LSB = cmd_data_lsb(DATA_WIDTH, ADDR_WIDTH);
  localparam int CNT_W    = clog2(CMD_DEPTH) + 1;
  localparam int PEND_W   = clog2(MAX_PENDING_READS + 1);

  logic [CMD_W-1:0]      cmd_in, cmd_head;
  logic                  cmd_push, cmd_pop;
  logic                  fifo_full, fifo_empty;
  logic [CNT_W-1:0]      fifo_count;
  logic                  head_rd, head_wr;
  logic [ADDR_WIDTH-1:0] head_addr;
  logic                  rd_accept;
  logic                  credit_ok;

  logic [PEND_W-1:0]     pend_q, pend_d;
  logic                  rdv_q, rdv_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  eop_q, eop_d;

  // ---------------- command accept ----------------
  assign cmd_in            = {slave_writedata, slave_address, slave_read, slave_write, slave_byteenable};
  // Full is a registered decode, so a same-cycle pop never lets a push in.
  assign slave_waitrequest = fifo_full;
  assign cmd_push          = (slave_read | slave_write) & ~fifo_full;

  avalon_bridge_cmd_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (CMD_DEPTH)
  ) u_cmd_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (cmd_push),
    .pop   (cmd_pop),
    .wdata (cmd_in),
    .rdata (cmd_head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // ---------------- master issue ----------------
  // Head fields drive the master bus directly; they only move on a pop, so a
  // held command stays stable under master_waitrequest.
  assign head_wr           = cmd_head[WR_BIT];
  assign head_rd           = cmd_head[RD_BIT];
  assign head_addr         = cmd_head[ADDR_LSB +: ADDR_WIDTH];
  assign master_byteenable = cmd_head[CMD_BE_LSB +: BE];
  assign master_writedata  = cmd_head[DATA_LSB +: DATA_WIDTH];
  assign master_address    = MA_W'(head_addr) << BA;

  // Credit can only grow while a read is held, so master_read never drops mid-wait.
  assign credit_ok    = (pend_q < PEND_W'(MAX_PENDING_READS));
  assign master_write = ~fifo_empty & head_wr;
  assign master_read  = ~fifo_empty & head_rd & credit_ok;
  assign cmd_pop      = (master_read | master_write) & ~master_waitrequest;
  assign rd_accept    = master_read & ~master_waitrequest;

  // Outstanding-read counter: accept and return in one cycle cancel; a stray
  // return with nothing outstanding is ignored so the count never wraps.
  always_comb begin
    pend_d = pend_q;
    if (rd_accept && !master_readdatavalid)
      pend_d = pend_q + PEND_W'(1);
    else if (!rd_accept && master_readdatavalid && (pend_q != '0))
      pend_d = pend_q - PEND_W'(1);
  end

  // Response stage: valid always follows, data/eop hold between beats.
  always_comb begin
    rdv_d   = master_readdatavalid;
    rdata_d = master_readdatavalid ? master_readdata    : rdata_q;
    eop_d   = master_readdatavalid ? master_endofpacket : eop_q;
  end

  // Pending counter and response registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_q  <= '0;
      rdv_q   <= 1'b0;
      rdata_q <= '0;
      eop_q   <= 1'b0;
    end else begin
      pend_q  <= pend_d;
      rdv_q   <= rdv_d;
      rdata_q <= rdata_d;
      eop_q   <= eop_d;
    end
  end

  assign slave_readdatavalid = rdv_q;
  assign slave_readdata      = rdata_q;
  assign slave_endofpacket   = eop_q;
  assign bridge_idle         = (fifo_count == '0) & (pend_q == '0);

endmodule

// File: tb/tb_avalon_pipeline_bridge.sv
// Self-checking bench for avalon_pipeline_bridge: directed scenarios plus a
// randomized run, all checked against a queue-based transaction model.
`timescale 1ns/1ps
module tb_avalon_pipeline_bridge;

  localparam int DW    = 64;
  localparam int AW    = 23;
  localparam int DEPTH = 8;
  localparam int MPR   = 2;
  localparam int BE    = DW / 8;
  localparam int BA    = 3;
  localparam int MAW   = AW + BA;
  localparam int NRAND = 40;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [AW-1:0]  slave_address = '0;
  logic [BE-1:0]  slave_byteenable = '0;
  logic           slave_read = 1'b0;
  logic           slave_write = 1'b0;
  logic [DW-1:0]  slave_writedata = '0;
  logic           slave_waitrequest;
  logic [DW-1:0]  slave_readdata;
  logic           slave_readdatavalid;
  logic           slave_endofpacket;
  logic [MAW-1:0] master_address;
  logic [BE-1:0]  master_byteenable;
  logic           master_read;
  logic           master_write;
  logic [DW-1:0]  master_writedata;
  logic           master_waitrequest = 1'b0;
  logic [DW-1:0]  master_readdata = '0;
  logic           master_readdatavalid = 1'b0;
  logic           master_endofpacket = 1'b0;
  logic           bridge_idle;

  always #5 clk = ~clk;

  avalon_pipeline_bridge #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CMD_DEPTH(DEPTH), .MAX_PENDING_READS(MPR)
  ) dut (
    .clk(clk), .reset(reset),
    .slave_address(slave_address), .slave_byteenable(slave_byteenable),
    .slave_read(slave_read), .slave_write(slave_write),
    .slave_writedata(slave_writedata), .slave_waitrequest(slave_waitrequest),
    .slave_readdata(slave_readdata), .slave_readdatavalid(slave_readdatavalid),
    .slave_endofpacket(slave_endofpacket),
    .master_address(master_address), .master_byteenable(master_byteenable),
    .master_read(master_read), .master_write(master_write),
    .master_writedata(master_writedata), .master_waitrequest(master_waitrequest),
    .master_readdata(master_readdata), .master_readdatavalid(master_readdatavalid),
    .master_endofpacket(master_endofpacket), .bridge_idle(bridge_idle)
  );

  // ---------------- transaction model ----------------
  typedef struct {
    logic [AW-1:0] addr;
    logic [BE-1:0] be;
    logic          rd;
    logic          wr;
    logic [DW-1:0] wd;
  } cmd_t;

  cmd_t          mq[$];          // commands accepted from the slave, not yet taken by the master
  int            pend = 0;       // reads taken by the master, not yet returned
  logic          e_rdv = 1'b0;
  logic [DW-1:0] e_rdata = '0;
  logic          e_eop = 1'b0;
  int            tests_run = 0;
  int            tests_failed = 0;

  function automatic bit mdl_full();
    return mq.size() == DEPTH;
  endfunction

  function automatic bit mdl_wr();
    if (mq.size() == 0) return 1'b0;
    return mq[0].wr;
  endfunction

  function automatic bit mdl_rd();
    if (mq.size() == 0) return 1'b0;
    return mq[0].rd && (pend < MPR);
  endfunction

  function automatic bit mdl_idle();
    return (mq.size() == 0) && (pend == 0);
  endfunction

  function automatic logic [DW-1:0] rand64();
    return {$urandom(), $urandom()};
  endfunction

  task automatic mdl_clear();
    mq.delete();
    pend    = 0;
    e_rdv   = 1'b0;
    e_rdata = '0;
    e_eop   = 1'b0;
  endtask

  task automatic quiet();
    slave_read           = 1'b0;
    slave_write          = 1'b0;
    master_readdatavalid = 1'b0;
    master_endofpacket   = 1'b0;
  endtask

  // Advance one clock: apply the handshakes the model predicts for the
  // current inputs, then settle 1 ns past the edge.
  task automatic tick();
    bit   push, rd_go, pop;
    cmd_t c;
    push  = (slave_read || slave_write) && !mdl_full();
    rd_go = mdl_rd() && !master_waitrequest;
    pop   = (mdl_rd() || mdl_wr()) && !master_waitrequest;
    if (rd_go && !master_readdatavalid) pend++;
    else if (!rd_go && master_readdatavalid && pend > 0) pend--;
    e_rdv = master_readdatavalid;
    if (master_readdatavalid) begin
      e_rdata = master_readdata;
      e_eop   = master_endofpacket;
    end
    if (pop) void'(mq.pop_front());
    if (push) begin
      c.addr = slave_address; c.be = slave_byteenable;
      c.rd = slave_read; c.wr = slave_write; c.wd = slave_writedata;
      mq.push_back(c);
    end
    @(posedge clk); #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    quiet();
    master_waitrequest = 1'b0;
    reset = 1'b1;
    mdl_clear();
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if ({slave_waitrequest, slave_readdatavalid, slave_endofpacket, master_read, master_write, bridge_idle} !== 6'b000001) begin
      tests_failed++;
      $display("FAIL reset_flags: got %b want 000001",
        {slave_waitrequest, slave_readdatavalid, slave_endofpacket, master_read, master_write, bridge_idle});
    end
    tests_run++;
    if (slave_readdata !== '0 || master_address !== '0 || master_writedata !== '0 || master_byteenable !== '0) begin
      tests_failed++;
      $display("FAIL reset_data: got rdata=%h addr=%h wdata=%h be=%h want all zero",
        slave_readdata, master_address, master_writedata, master_byteenable);
    end
    reset = 1'b0;
    tick();
    tests_run++;
    if ({slave_waitrequest, master_read, master_write, bridge_idle} !== 4'b0001) begin
      tests_failed++;
      $display("FAIL reset_release: got %b want 0001", {slave_waitrequest, master_read, master_write, bridge_idle});
    end
  endtask

  task automatic test_back_to_back();
    quiet();
    master_waitrequest = 1'b0;
    slave_byteenable = '1;
    for (int i = 0; i < 8; i++) begin
      slave_write = 1'b1; slave_address = AW'(i); slave_writedata = DW'(i);
      if (i == 0) begin
        tests_run++;
        if (master_write !== 1'b0) begin
          tests_failed++;
          $display("FAIL b2b_cycle0: got master_write=%b want 0", master_write);
        end
      end
      tick();
      tests_run++;
      if ({master_write, master_read, master_address, master_writedata} !== {1'b1, 1'b0, MAW'(i * 8), DW'(i)}) begin
        tests_failed++;
        $display("FAIL b2b_issue[%0d]: got wr=%b rd=%b addr=%h data=%h want wr=1 rd=0 addr=%h data=%h",
          i, master_write, master_read, master_address, master_writedata, MAW'(i * 8), DW'(i));
      end
    end
    slave_write = 1'b0;
    tick();
    tests_run++;
    if ({master_write, bridge_idle} !== 2'b01) begin
      tests_failed++;
      $display("FAIL b2b_drain: got wr=%b idle=%b want wr=0 idle=1", master_write, bridge_idle);
    end
  endtask

  task automatic test_backpressure();
    logic [AW-1:0] addrs [9];
    logic [DW-1:0] datas [9];
    int            issued;
    bit            acc;
    quiet();
    master_waitrequest = 1'b1;
    for (int i = 0; i < 9; i++) begin
      addrs[i] = AW'($urandom); datas[i] = rand64();
      slave_write = 1'b1; slave_address = addrs[i]; slave_writedata = datas[i];
      slave_byteenable = BE'($urandom);
      tests_run++;
      if (slave_waitrequest !== (i == 8)) begin
        tests_failed++;
        $display("FAIL bp_waitrequest[%0d]: got %b want %b", i, slave_waitrequest, (i == 8));
      end
      if (i < 8) tick();
    end
    tick();  // 9th held: FIFO full, master stalled
    tests_run++;
    if ({master_write, master_address, master_writedata} !== {1'b1, addrs[0], 3'b000, datas[0]} || slave_waitrequest !== 1'b1) begin
      tests_failed++;
      $display("FAIL bp_hold: got wr=%b addr=%h data=%h swait=%b want wr=1 addr=%h data=%h swait=1",
        master_write, master_address, master_writedata, slave_waitrequest, {addrs[0], 3'b000}, datas[0]);
    end
    master_waitrequest = 1'b0;
    issued = 0;
    for (int c = 0; c < 30 && issued < 9; c++) begin
      tests_run++;
      if (slave_waitrequest !== mdl_full()) begin
        tests_failed++;
        $display("FAIL bp_release_wait[%0d]: got %b want %b", c, slave_waitrequest, mdl_full());
      end
      if (master_write === 1'b1) begin
        tests_run++;
        if (master_address !== {addrs[issued], 3'b000} || master_writedata !== datas[issued]) begin
          tests_failed++;
          $display("FAIL bp_order[%0d]: got addr=%h data=%h want addr=%h data=%h",
            issued, master_address, master_writedata, {addrs[issued], 3'b000}, datas[issued]);
        end
        issued++;
      end
      acc = slave_write && !mdl_full();
      tick();
      if (acc) slave_write = 1'b0;
    end
    tests_run++;
    if (issued != 9 || bridge_idle !== 1'b1) begin
      tests_failed++;
      $display("FAIL bp_drain_count: got issued=%0d idle=%b want issued=9 idle=1", issued, bridge_idle);
    end
    quiet();
  endtask

  task automatic test_read_credit();
    int            nrd;
    logic [DW-1:0] d;
    logic          e;
    quiet();
    master_waitrequest = 1'b0;
    nrd = 0;
    for (int c = 0; c < 10; c++) begin
      slave_read = (c < 4);
      slave_address = AW'($urandom); slave_byteenable = '1;
      if (master_read === 1'b1) nrd++;
      tick();
    end
    slave_read = 1'b0;
    tests_run++;
    if (nrd != MPR || master_read !== 1'b0 || bridge_idle !== 1'b0) begin
      tests_failed++;
      $display("FAIL credit_limit: got reads=%0d rd=%b idle=%b want reads=%0d rd=0 idle=0", nrd, master_read, bridge_idle, MPR);
    end
    d = rand64(); e = ($urandom_range(0, 1) == 1);
    master_readdatavalid = 1'b1; master_readdata = d; master_endofpacket = e;
    tick();
    master_readdatavalid = 1'b0;
    tests_run++;
    if ({slave_readdatavalid, slave_endofpacket, master_read} !== {1'b1, e, 1'b1} || slave_readdata !== d) begin
      tests_failed++;
      $display("FAIL credit_return: got rdv=%b eop=%b rd=%b data=%h want rdv=1 eop=%b rd=1 data=%h",
        slave_readdatavalid, slave_endofpacket, master_read, slave_readdata, e, d);
    end
    tick();
    tests_run++;
    if (master_read !== 1'b0) begin
      tests_failed++;
      $display("FAIL credit_refill: got master_read=%b want 0", master_read);
    end
    for (int c = 0; c < 30 && !mdl_idle(); c++) begin
      master_readdatavalid = (pend > 0);
      master_readdata = rand64();
      tick();
    end
    master_readdatavalid = 1'b0;
    tick();
    tests_run++;
    if (bridge_idle !== 1'b1) begin
      tests_failed++;
      $display("FAIL credit_drain: got idle=%b want 1", bridge_idle);
    end
  endtask

  task automatic test_same_cycle();
    logic [DW-1:0] d;
    quiet();
    master_waitrequest = 1'b0;
    slave_read = 1'b1; slave_address = AW'($urandom); slave_byteenable = '1;
    tick();
    slave_read = 1'b0;
    tick();  // first read taken, one outstanding
    slave_read = 1'b1; slave_address = AW'($urandom);
    tick();
    slave_read = 1'b0;
    tests_run++;
    if ({master_read, bridge_idle} !== 2'b10) begin
      tests_failed++;
      $display("FAIL same_pre: got rd=%b idle=%b want rd=1 idle=0", master_read, bridge_idle);
    end
    d = rand64();
    master_readdatavalid = 1'b1; master_readdata = d; master_endofpacket = 1'b1;
    tick();
    master_readdatavalid = 1'b0; master_endofpacket = 1'b0;
    tests_run++;
    if ({slave_readdatavalid, slave_endofpacket, bridge_idle, master_read} !== 4'b1100 || slave_readdata !== d) begin
      tests_failed++;
      $display("FAIL same_cycle: got rdv=%b eop=%b idle=%b rd=%b data=%h want 1100 data=%h",
        slave_readdatavalid, slave_endofpacket, bridge_idle, master_read, slave_readdata, d);
    end
    tick();
    tests_run++;
    if (slave_readdatavalid !== 1'b0 || slave_readdata !== d || slave_endofpacket !== 1'b1) begin
      tests_failed++;
      $display("FAIL same_hold: got rdv=%b eop=%b data=%h want rdv=0 eop=1 data=%h",
        slave_readdatavalid, slave_endofpacket, slave_readdata, d);
    end
    master_readdatavalid = 1'b1; master_readdata = rand64();
    tick();
    master_readdatavalid = 1'b0;
    tests_run++;
    if (bridge_idle !== 1'b1) begin
      tests_failed++;
      $display("FAIL same_last_return: got idle=%b want 1", bridge_idle);
    end
  endtask

  task automatic test_stray_readdata();
    logic [DW-1:0] d;
    quiet();
    master_waitrequest = 1'b0;
    d = rand64();
    master_readdatavalid = 1'b1; master_readdata = d; master_endofpacket = 1'b1;
    tick();
    master_readdatavalid = 1'b0; master_endofpacket = 1'b0;
    tests_run++;
    if ({slave_readdatavalid, slave_endofpacket, bridge_idle} !== 3'b111 || slave_readdata !== d) begin
      tests_failed++;
      $display("FAIL stray_forward: got rdv=%b eop=%b idle=%b data=%h want 111 data=%h",
        slave_readdatavalid, slave_endofpacket, bridge_idle, slave_readdata, d);
    end
    slave_read = 1'b1; slave_address = AW'($urandom); slave_byteenable = '1;
    tick();
    slave_read = 1'b0;
    tick();
    tests_run++;
    if (bridge_idle !== 1'b0 || mdl_idle()) begin
      tests_failed++;
      $display("FAIL stray_issue: got idle=%b want 0", bridge_idle);
    end
    d = rand64();
    master_readdatavalid = 1'b1; master_readdata = d;
    tick();
    master_readdatavalid = 1'b0;
    tests_run++;
    if (bridge_idle !== 1'b1 || slave_readdata !== d) begin
      tests_failed++;
      $display("FAIL stray_no_underflow: got idle=%b data=%h want idle=1 data=%h", bridge_idle, slave_readdata, d);
    end
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] d;
    quiet();
    master_waitrequest = 1'b0;
    for (int i = 0; i < 2; i++) begin
      slave_read = 1'b1; slave_address = AW'($urandom); slave_byteenable = '1;
      tick();
    end
    slave_read = 1'b0;
    tick();
    tick();
    master_waitrequest = 1'b1;
    for (int i = 0; i < 5; i++) begin
      slave_write = 1'b1; slave_address = AW'($urandom); slave_writedata = rand64();
      tick();
    end
    slave_write = 1'b0;
    tests_run++;
    if ({master_write, master_read, bridge_idle} !== 3'b100) begin
      tests_failed++;
      $display("FAIL mid_loaded: got wr=%b rd=%b idle=%b want 100", master_write, master_read, bridge_idle);
    end
    #2;
    reset = 1'b1;
    #1;
    mdl_clear();
    tests_run++;
    if ({master_write, master_read, bridge_idle, slave_waitrequest} !== 4'b0010) begin
      tests_failed++;
      $display("FAIL mid_reset_async: got wr=%b rd=%b idle=%b swait=%b want 0010",
        master_write, master_read, bridge_idle, slave_waitrequest);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    master_waitrequest = 1'b0;
    tests_run++;
    if ({master_write, master_read, bridge_idle} !== 3'b001) begin
      tests_failed++;
      $display("FAIL mid_reset_next: got wr=%b rd=%b idle=%b want 001", master_write, master_read, bridge_idle);
    end
    d = rand64();
    master_readdatavalid = 1'b1; master_readdata = d;
    tick();
    master_readdatavalid = 1'b0;
    tests_run++;
    if ({slave_readdatavalid, bridge_idle} !== 2'b11 || slave_readdata !== d) begin
      tests_failed++;
      $display("FAIL mid_late_data: got rdv=%b idle=%b data=%h want rdv=1 idle=1 data=%h",
        slave_readdatavalid, bridge_idle, slave_readdata, d);
    end
    tick();
  endtask

  task automatic test_random_wrap();
    int sent;
    int cyc;
    bit acc;
    bit rd;
    quiet();
    sent = 0;
    cyc = 0;
    while ((sent < NRAND || !mdl_idle()) && cyc < 2000) begin
      cyc++;
      tests_run++;
      if ({slave_waitrequest, master_read, master_write, bridge_idle} !== {mdl_full(), mdl_rd(), mdl_wr(), mdl_idle()}) begin
        tests_failed++;
        $display("FAIL rand_ctrl[%0d]: got swait/rd/wr/idle=%b want %b", cyc,
          {slave_waitrequest, master_read, master_write, bridge_idle}, {mdl_full(), mdl_rd(), mdl_wr(), mdl_idle()});
      end
      if (mdl_rd() || mdl_wr()) begin
        tests_run++;
        if (master_address !== {mq[0].addr, 3'b000} || master_byteenable !== mq[0].be ||
            (mq[0].wr && master_writedata !== mq[0].wd)) begin
          tests_failed++;
          $display("FAIL rand_head[%0d]: got addr=%h be=%h data=%h want addr=%h be=%h data=%h", cyc,
            master_address, master_byteenable, master_writedata, {mq[0].addr, 3'b000}, mq[0].be, mq[0].wd);
        end
      end
      tests_run++;
      if (slave_readdatavalid !== e_rdv || (e_rdv && (slave_readdata !== e_rdata || slave_endofpacket !== e_eop))) begin
        tests_failed++;
        $display("FAIL rand_resp[%0d]: got rdv=%b data=%h eop=%b want rdv=%b data=%h eop=%b", cyc,
          slave_readdatavalid, slave_readdata, slave_endofpacket, e_rdv, e_rdata, e_eop);
      end
      if (!slave_read && !slave_write && sent < NRAND && $urandom_range(0, 3) != 0) begin
        rd = ($urandom_range(0, 1) == 1);
        slave_read = rd; slave_write = !rd;
        slave_address = AW'($urandom); slave_byteenable = BE'($urandom);
        slave_writedata = rand64();
      end
      master_waitrequest   = ($urandom_range(0, 3) == 0);
      master_readdatavalid = (pend > 0) && ($urandom_range(0, 2) == 0);
      master_readdata      = rand64();
      master_endofpacket   = ($urandom_range(0, 1) == 1);
      acc = (slave_read || slave_write) && !mdl_full();
      tick();
      if (acc) begin
        slave_read = 1'b0; slave_write = 1'b0;
        sent++;
      end
    end
    quiet();
    master_waitrequest = 1'b0;
    tests_run++;
    if (sent != NRAND || bridge_idle !== 1'b1) begin
      tests_failed++;
      $display("FAIL rand_drain: got sent=%0d idle=%b want sent=%0d idle=1", sent, bridge_idle, NRAND);
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_backpressure();
    test_read_credit();
    test_same_cycle();
    test_stray_readdata();
    test_reset_mid();
    test_random_wrap();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
